// File: rtl/memcpy_pkg.sv
// Shared types for the memcpy command dispatcher: operand widths, command
// record and dispatcher FSM states.
package memcpy_pkg;

    localparam int ADDR_W = 64;
    localparam int SIZE_W = 15;

    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [SIZE_W-1:0] size;
    } memcpy_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        CPL
    } dispatch_state_t;

endpackage

// File: rtl/memcpy_cmd_fifo.sv
// Command FIFO for the memcpy dispatcher: power-of-two depth, show-ahead head,
// occupancy count and asynchronous active-high reset of pointers and count.
module memcpy_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        // NOTE: every _d takes its held value first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the count decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/memcpy_dispatch.sv
// Buffers memcpy commands and issues them one at a time, holding operands
// stable and returning an id-tagged completion; zero-size copies bypass memcpy.
module memcpy_dispatch
    import memcpy_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_W-1:0]      cmd_src,
    input  logic [ADDR_W-1:0]      cmd_dst,
    input  logic [SIZE_W-1:0]      cmd_size,
    input  logic [ID_W-1:0]        cmd_id,
    output logic                   mc_en,
    output logic [ADDR_W-1:0]      mc_src,
    output logic [ADDR_W-1:0]      mc_dst,
    output logic [SIZE_W-1:0]      mc_size,
    input  logic                   mc_done,
    output logic                   cpl_valid,
    input  logic                   cpl_ready,
    output logic [ID_W-1:0]        cpl_id,
    output logic                   cpl_skipped,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    typedef struct packed {
        memcpy_cmd_t     cmd;
        logic [ID_W-1:0] id;
    } entry_t;

    entry_t          push_entry;
    entry_t          head;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;

    dispatch_state_t state_q, state_d;
    logic            mc_en_q, mc_en_d;
    memcpy_cmd_t     mc_q, mc_d;
    logic            cpl_valid_q, cpl_valid_d;
    logic [ID_W-1:0] cpl_id_q, cpl_id_d;
    logic            cpl_skipped_q, cpl_skipped_d;

    assign push_entry = '{cmd: '{src: cmd_src, dst: cmd_dst, size: cmd_size}, id: cmd_id};
    assign fifo_pop   = (state_q == IDLE) && !fifo_empty;

    memcpy_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        mc_en_d       = 1'b0;
        mc_d          = mc_q;
        cpl_valid_d   = cpl_valid_q;
        cpl_id_d      = cpl_id_q;
        cpl_skipped_d = cpl_skipped_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    mc_d     = head.cmd;
                    cpl_id_d = head.id;
                    // memcpy never finishes a zero-length copy, so answer it here
                    if (head.cmd.size != '0) begin
                        mc_en_d = 1'b1;
                        state_d = LAUNCH;
                    end else begin
                        cpl_valid_d   = 1'b1;
                        cpl_skipped_d = 1'b1;
                        state_d       = CPL;
                    end
                end
            end
            LAUNCH: state_d = WAIT;
            WAIT: begin
                if (mc_done) begin
                    cpl_valid_d   = 1'b1;
                    cpl_skipped_d = 1'b0;
                    state_d       = CPL;
                end
            end
            CPL: begin
                if (cpl_ready) begin
                    cpl_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            mc_en_q       <= 1'b0;
            mc_q          <= '0;
            cpl_valid_q   <= 1'b0;
            cpl_id_q      <= '0;
            cpl_skipped_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mc_en_q       <= mc_en_d;
            mc_q          <= mc_d;
            cpl_valid_q   <= cpl_valid_d;
            cpl_id_q      <= cpl_id_d;
            cpl_skipped_q <= cpl_skipped_d;
        end
    end

    assign cmd_ready   = !fifo_full;
    assign mc_en       = mc_en_q;
    assign mc_src      = mc_q.src;
    assign mc_dst      = mc_q.dst;
    assign mc_size     = mc_q.size;
    assign cpl_valid   = cpl_valid_q;
    assign cpl_id      = cpl_id_q;
    assign cpl_skipped = cpl_skipped_q;
    assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_memcpy_dispatch.sv
// Self-checking bench for memcpy_dispatch: memcpy responder model, launch and
// completion scoreboards, table-driven vectors and hand-written corner sequences.
module tb_memcpy_dispatch;

    typedef struct {
        logic [63:0] src;
        logic [63:0] dst;
        logic [14:0] size;
    } launch_t;

    typedef struct {
        logic [3:0] id;
        logic       skipped;
    } cpl_t;

    typedef struct {
        logic [63:0] src;
        logic [63:0] dst;
        logic [14:0] size;
        logic [3:0]  id;
        int          delay;
        logic        exp_skip;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_src;
    logic [63:0] cmd_dst;
    logic [14:0] cmd_size;
    logic [3:0]  cmd_id;
    logic        mc_en;
    logic [63:0] mc_src;
    logic [63:0] mc_dst;
    logic [14:0] mc_size;
    logic        mc_done;
    logic        cpl_valid;
    logic        cpl_ready;
    logic [3:0]  cpl_id;
    logic        cpl_skipped;
    logic        busy;
    logic [2:0]  fifo_count;

    logic        done_resp;
    logic        done_man;
    int          done_delay;

    int          checks;
    int          errors;

    launch_t     launch_q[$];
    cpl_t        cpl_q[$];
    logic        inflight;
    logic        prev_mc_en;
    logic [142:0] held;

    assign mc_done = done_resp | done_man;

    memcpy_dispatch #(
        .DEPTH (4),
        .ID_W  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_src     (cmd_src),
        .cmd_dst     (cmd_dst),
        .cmd_size    (cmd_size),
        .cmd_id      (cmd_id),
        .mc_en       (mc_en),
        .mc_src      (mc_src),
        .mc_dst      (mc_dst),
        .mc_size     (mc_size),
        .mc_done     (mc_done),
        .cpl_valid   (cpl_valid),
        .cpl_ready   (cpl_ready),
        .cpl_id      (cpl_id),
        .cpl_skipped (cpl_skipped),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_mc_en", mc_en, 0);
        check("rst_mc_src", mc_src, 0);
        check("rst_mc_dst", mc_dst, 0);
        check("rst_mc_size", mc_size, 0);
        check("rst_cpl_valid", cpl_valid, 0);
        check("rst_cpl_id", cpl_id, 0);
        check("rst_cpl_skipped", cpl_skipped, 0);
        check("rst_busy", busy, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_cmd_ready", cmd_ready, 1);
    endtask

    // Drive one command from a negedge; returns at the negedge after its handshake.
    task automatic push_cmd(input logic [63:0] s, input logic [63:0] d, input logic [14:0] sz,
                            input logic [3:0] id, input logic skip);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_src   = s;
        cmd_dst   = d;
        cmd_size  = sz;
        cmd_id    = id;
        while (!cmd_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("push_accepted", cmd_ready, 1);
        if (cmd_ready) begin
            if (!skip) launch_q.push_back('{src: s, dst: d, size: sz});
            cpl_q.push_back('{id: id, skipped: skip});
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || cpl_valid || cpl_q.size() != 0 || launch_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", !busy && cpl_q.size() == 0 && launch_q.size() == 0, 1);
    endtask

    task automatic wait_cpl(input int budget);
        int n = 0;
        while (!cpl_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("cpl_valid_seen", cpl_valid, 1);
    endtask

    // memcpy model: done_delay negedges after seeing mc_en, pulse mc_done for one cycle.
    initial begin
        done_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (mc_en === 1'b1 && !reset) begin
                int   dl;
                logic aborted;
                dl      = done_delay;
                aborted = 1'b0;
                for (int i = 0; i < dl; i++) begin
                    @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    done_resp = 1'b1;
                    @(negedge clk);
                    done_resp = 1'b0;
                    if (!reset) check("cpl_cycle_after_done", cpl_valid, 1);
                end
            end
        end
    end

    // Scoreboard monitor, sampled just after the negedge so bench input updates have settled.
    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            inflight   <= 1'b0;
            prev_mc_en <= 1'b0;
        end else begin
            if (mc_en) begin
                check("mc_en_one_cycle", prev_mc_en, 0);
                check("launch_expected", launch_q.size() != 0, 1);
                if (launch_q.size() != 0) begin
                    check("mc_operands", {mc_src, mc_dst, mc_size},
                          {launch_q[0].src, launch_q[0].dst, launch_q[0].size});
                    void'(launch_q.pop_front());
                end
                held     <= {mc_src, mc_dst, mc_size};
                inflight <= 1'b1;
            end else if (inflight) begin
                check("mc_hold", {mc_src, mc_dst, mc_size}, held);
            end
            if (cpl_valid && cpl_ready) begin
                check("cpl_expected", cpl_q.size() != 0, 1);
                if (cpl_q.size() != 0) begin
                    check("cpl_id", cpl_id, cpl_q[0].id);
                    check("cpl_skipped", cpl_skipped, cpl_q[0].skipped);
                    void'(cpl_q.pop_front());
                end
                inflight <= 1'b0;
            end
            prev_mc_en <= mc_en;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{src: 64'h0, dst: 64'hFFFF_FFFF_FFFF_FFFF, size: 15'd1, id: 4'd0, delay: 1, exp_skip: 1'b0};
        vecs[1] = '{src: 64'h8000_0000_0000_0000, dst: 64'h10, size: 15'h7FFF, id: 4'd15, delay: 2, exp_skip: 1'b0};
        vecs[2] = '{src: 64'h1234, dst: 64'h5678, size: 15'd0, id: 4'd6, delay: 1, exp_skip: 1'b1};
        vecs[3] = '{src: 64'hDEAD_BEEF_0000_0040, dst: 64'hCAFE_0000_0000_0080, size: 15'h100, id: 4'd9, delay: 7, exp_skip: 1'b0};
        vecs[4] = '{src: 64'hA5A5_A5A5_A5A5_A5A5, dst: 64'h5A5A_5A5A_5A5A_5A5A, size: 15'd0, id: 4'd12, delay: 1, exp_skip: 1'b1};

        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_src    = '0;
        cmd_dst    = '0;
        cmd_size   = '0;
        cmd_id     = '0;
        cpl_ready  = 1'b1;
        done_man   = 1'b0;
        done_delay = 40;

        repeat (2) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        @(negedge clk);

        // Test 1: normal copy with a 40-cycle memcpy
        push_cmd(64'h1000, 64'h2000, 15'd16, 4'd3, 1'b0);
        check("t1_count_after_push", fifo_count, 1);
        check("t1_no_early_en", mc_en, 0);
        check("t1_busy", busy, 1);
        @(negedge clk);
        check("t1_mc_en", mc_en, 1);
        check("t1_mc_src", mc_src, 64'h1000);
        check("t1_mc_dst", mc_dst, 64'h2000);
        check("t1_mc_size", mc_size, 16);
        check("t1_count_after_pop", fifo_count, 0);
        @(negedge clk);
        check("t1_mc_en_dropped", mc_en, 0);
        wait_idle(100);

        // Test 2: zero-size command never reaches memcpy
        push_cmd(64'h3000, 64'h4000, 15'd0, 4'd5, 1'b0 | 1'b1);
        check("t2_no_en_a", mc_en, 0);
        check("t2_cpl_not_yet", cpl_valid, 0);
        @(negedge clk);
        check("t2_no_en_b", mc_en, 0);
        check("t2_cpl_valid", cpl_valid, 1);
        check("t2_cpl_id", cpl_id, 5);
        check("t2_cpl_skipped", cpl_skipped, 1);
        wait_idle(20);

        // Table-driven vectors, one command at a time
        for (int i = 0; i < 5; i++) begin
            done_delay = vecs[i].delay;
            push_cmd(vecs[i].src, vecs[i].dst, vecs[i].size, vecs[i].id, vecs[i].exp_skip);
            wait_idle(100);
        end

        // Test 3: fill the FIFO behind a stalled completion
        done_delay = 3;
        cpl_ready  = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++)
                    push_cmd(64'h100 * i, 64'h9000 + 64'h10 * i, 15'(8 * i), 4'(i), 1'b0);
            end
            begin
                repeat (12) @(negedge clk);
                check("t3_fifo_full_count", fifo_count, 4);
                check("t3_cmd_ready_low", cmd_ready, 0);
                check("t3_first_cpl_valid", cpl_valid, 1);
                check("t3_first_cpl_id", cpl_id, 1);
                cpl_ready = 1'b1;
            end
        join
        wait_idle(300);

        // Test 4: completion held for 10+ cycles while the FIFO keeps accepting
        done_delay = 5;
        cpl_ready  = 1'b0;
        push_cmd(64'h7000, 64'h7100, 15'h40, 4'd7, 1'b0);
        wait_cpl(50);
        push_cmd(64'h8000, 64'h8100, 15'h20, 4'd8, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("t4_cpl_valid_hold", cpl_valid, 1);
            check("t4_cpl_id_hold", cpl_id, 7);
            check("t4_no_launch", mc_en, 0);
            @(negedge clk);
        end
        check("t4_fifo_count", fifo_count, 1);
        cpl_ready = 1'b1;
        wait_idle(100);

        // Test 5: stray mc_done in IDLE and in CPL
        done_man = 1'b1;
        @(negedge clk);
        done_man = 1'b0;
        check("t5_idle_no_cpl", cpl_valid, 0);
        check("t5_idle_not_busy", busy, 0);
        @(negedge clk);
        check("t5_idle_no_cpl_b", cpl_valid, 0);
        done_delay = 3;
        cpl_ready  = 1'b0;
        push_cmd(64'hA000, 64'hB000, 15'd4, 4'd9, 1'b0);
        wait_cpl(50);
        done_man = 1'b1;
        @(negedge clk);
        done_man = 1'b0;
        check("t5_cpl_hold_valid", cpl_valid, 1);
        check("t5_cpl_hold_id", cpl_id, 9);
        check("t5_cpl_hold_skipped", cpl_skipped, 0);
        @(negedge clk);
        check("t5_no_launch", mc_en, 0);
        cpl_ready = 1'b1;
        wait_idle(50);
        repeat (3) @(negedge clk);
        check("t5_no_spurious_cpl", cpl_valid, 0);

        // Test 6: asynchronous reset mid-WAIT with three commands queued
        done_delay = 40;
        push_cmd(64'hC000, 64'hD000, 15'h100, 4'd10, 1'b0);
        @(negedge clk);
        check("t6_launched", mc_en, 1);
        push_cmd(64'hC100, 64'hD100, 15'h10, 4'd11, 1'b0);
        push_cmd(64'hC200, 64'hD200, 15'd0, 4'd12, 1'b1);
        push_cmd(64'hC300, 64'hD300, 15'h30, 4'd13, 1'b0);
        check("t6_queued", fifo_count, 3);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs();
        launch_q.delete();
        cpl_q.delete();
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        done_delay = 4;
        push_cmd(64'hE000, 64'hF000, 15'h20, 4'd14, 1'b0);
        @(negedge clk);
        check("t6_post_reset_en", mc_en, 1);
        check("t6_post_reset_src", mc_src, 64'hE000);
        wait_idle(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
